// File: rtl/axis_frame_host.sv
// axis_frame_host: host-side frame driver for the accelerator stream ports.
// Holds one TX frame in a register file, streams it out as an AXIS master,
// then captures the returned result frame as an AXIS slave.
// Optional: define AXIS_FRAME_HOST_ARGMAX_EN to add a running signed argmax
// over the received words and the class_idx output.
module axis_frame_host #(
    parameter int DATA_WIDTH   = 32,
    parameter int TX_NUM       = 8,
    parameter int RX_NUM       = 4,
    parameter int TX_ADR_WIDTH = 8,
    parameter int RX_ADR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    host_wr,
    input  logic [TX_ADR_WIDTH-1:0] host_wr_adr,
    input  logic [DATA_WIDTH-1:0]   host_wr_data,
    input  logic [RX_ADR_WIDTH-1:0] host_rd_adr,
    output logic [DATA_WIDTH-1:0]   host_rd_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err_last,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
    output logic [$clog2(RX_NUM)-1:0] class_idx,
`endif
    output logic                    s_ready
);

    localparam int TX_CW = $clog2(TX_NUM);
    localparam int RX_CW = $clog2(RX_NUM);
    localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(TX_NUM - 1);
    localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_NUM - 1);
    // one extra bit so TX_NUM/RX_NUM fit even when they equal 2**ADR_WIDTH
    localparam logic [TX_ADR_WIDTH:0] TX_LIM = (TX_ADR_WIDTH+1)'(TX_NUM);
    localparam logic [RX_ADR_WIDTH:0] RX_LIM = (RX_ADR_WIDTH+1)'(RX_NUM);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t            state_q, state_d;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic              err_q, err_d;
    logic              busy_q, done_q, m_valid_q, m_last_q, s_ready_q;
    logic              rx_we;
    logic              rx_end;

    logic [DATA_WIDTH-1:0] frame_mem  [TX_NUM];
    logic [DATA_WIDTH-1:0] result_mem [RX_NUM];

`ifdef AXIS_FRAME_HOST_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [RX_CW-1:0]             idx_q, idx_d, class_q, class_d;
`endif

    // next-state, counter and framing-error logic
    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        err_d    = err_q;
        rx_we    = 1'b0;
        rx_end   = s_last || (rx_cnt_q == RX_LAST);
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
        max_d    = max_q;
        idx_d    = idx_q;
        class_d  = class_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d  = SEND;
                tx_cnt_d = '0;
                rx_cnt_d = '0;
                err_d    = 1'b0;
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
                class_d  = '0;
`endif
            end
            SEND: if (m_ready) begin
                if (tx_cnt_q == TX_LAST) begin
                    state_d  = RECV;
                    tx_cnt_d = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            RECV: if (s_valid) begin
                rx_we    = 1'b1;
                rx_cnt_d = rx_cnt_q + 1'b1;
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
                // strict '>' keeps the lower index on ties
                if (rx_cnt_q == '0 || $signed(s_data) > max_q) begin
                    max_d = $signed(s_data);
                    idx_d = rx_cnt_q;
                end
`endif
                if (rx_end) begin
                    state_d = DONE;
                    // s_last must coincide exactly with the final slot
                    err_d   = s_last ^ (rx_cnt_q == RX_LAST);
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
                    class_d = idx_d;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; outputs derive from the next state so
    // they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b0;
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
            max_q     <= '0;
            idx_q     <= '0;
            class_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            m_valid_q <= (state_d == SEND);
            m_last_q  <= (state_d == SEND) && (tx_cnt_d == TX_LAST);
            s_ready_q <= (state_d == RECV);
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
            max_q     <= max_d;
            idx_q     <= idx_d;
            class_q   <= class_d;
`endif
        end
    end

    // frame memory: host writes are blocked while the frame is streaming
    always_ff @(posedge clk) begin
        if (host_wr && state_q != SEND && {1'b0, host_wr_adr} < TX_LIM)
            frame_mem[host_wr_adr[TX_CW-1:0]] <= host_wr_data;
    end

    // result buffer: captures each accepted slave word at rx_cnt
    always_ff @(posedge clk) begin
        if (rx_we)
            result_mem[rx_cnt_q] <= s_data;
    end

    assign host_rd_data = ({1'b0, host_rd_adr} < RX_LIM) ?
                          result_mem[host_rd_adr[RX_CW-1:0]] : '0;
    // frame memory is frozen during SEND, so m_data holds across stalls
    assign m_data   = frame_mem[tx_cnt_q];
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_last = err_q;
`ifdef AXIS_FRAME_HOST_ARGMAX_EN
    assign class_idx = class_q;
`endif

endmodule
